// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freeze with a bounded wait, sticky timeout flag and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    logic [7:0]       wait_cnt_r;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic mem_acc_s;
    logic load_use_s;
    logic tmo_s;
    logic freeze_s;

    assign mem_err   = mem_err_r;
    assign stall_cnt = stall_cnt_r;

    // Hazard detection; register $0 never produces a load-use stall.
    always_comb begin
        mem_acc_s  = exmem_memread | exmem_memwrite;
        load_use_s = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == id_rs) | (idex_rt == id_rt));
        tmo_s      = (state_r == MEM_WAIT) & (wait_cnt_r == TMO_LAST) & ~mem_ready;
        freeze_s   = mem_acc_s & ~mem_ready & ~tmo_s;
    end

    // Pipeline-register controls, prioritised reset > freeze > branch > load-use.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (load_use_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
        end else begin
            pc_write     = 1'b1;
            idex_flush   = 1'b0;
        end
    end

    // Memory-wait FSM with timeout and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
            mem_err_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    wait_cnt_r <= 8'd0;
                    if (mem_acc_s && !mem_ready) begin
                        state_r <= MEM_WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_acc_s || mem_ready) begin
                        state_r <= RUN;
                    end else if (tmo_s) begin
                        state_r   <= RUN;
                        mem_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4); inputs change on the
// falling edge and outputs are checked 1ns later, well before the next rising edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       idex_memread, branch_taken, exmem_memread, exmem_memwrite, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble;
    logic       mem_err;
    logic [3:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_FRZ  = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b1111111;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble};
        chk(tag, {25'd0, obs}, {25'd0, exp});
    endtask

    // Advance to the next falling edge and apply a new input vector.
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt, input logic br,
                        input logic emr, input logic emw, input logic rdy);
        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; idex_memread = mr; idex_rt = xrt;
        branch_taken = br; exmem_memread = emr; exmem_memwrite = emw; mem_ready = rdy;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; id_rs = 5'd0; id_rt = 5'd0; idex_memread = 1'b0; idex_rt = 5'd0;
        branch_taken = 1'b0; exmem_memread = 1'b0; exmem_memwrite = 1'b0; mem_ready = 1'b1;

        // Reset state
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_ctl("rst_ctl", C_RST);
        idle();
        chk_ctl("idle_ctl", C_NORM);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);

        // Load-use on rs and on rt
        step(1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_ctl("lu_rs_ctl", C_LU);
        idle();
        chk_ctl("lu_after_ctl", C_NORM);
        chk("lu_stall1", 32'(stall_cnt), 32'd1);
        step(1'b0, 5'd0, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_ctl("lu_rt_ctl", C_LU);

        // $0 and non-matching registers create no hazard
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_ctl("lu_r0_ctl", C_NORM);
        chk("lu_stall2", 32'(stall_cnt), 32'd2);
        step(1'b0, 5'd8, 5'd10, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_ctl("lu_nomatch_ctl", C_NORM);

        // Branch beats load-use; not counted as a stall
        step(1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_ctl("br_ctl", C_BR);
        idle();
        chk("br_stall", 32'(stall_cnt), 32'd2);

        // Memory wait: 3 not-ready cycles, released on mem_ready
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk_ctl("mw_frz_ctl", C_FRZ);
        end
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_ctl("mw_rel_ctl", C_NORM);
        idle();
        chk("mw_stall", 32'(stall_cnt), 32'd5);
        chk("mw_err", 32'(mem_err), 32'd0);

        // Freeze outranks branch and load-use; branch flushes on the ready cycle
        step(1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_ctl("pri_frz_ctl", C_FRZ);
        step(1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_ctl("pri_br_ctl", C_BR);
        idle();
        chk("pri_stall", 32'(stall_cnt), 32'd6);

        // Timeout: 4 frozen cycles, 5th advances, mem_err sticky afterwards
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_ctl("tmo_frz_ctl", C_FRZ);
        end
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_ctl("tmo_rel_ctl", C_NORM);
        chk("tmo_err_pre", 32'(mem_err), 32'd0);
        idle();
        chk_ctl("tmo_after_ctl", C_NORM);
        chk("tmo_err", 32'(mem_err), 32'd1);
        chk("tmo_stall", 32'(stall_cnt), 32'd10);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_ctl("zw_ctl", C_NORM);
        idle();
        chk("err_sticky", 32'(mem_err), 32'd1);

        // Reset during the 2nd wait cycle aborts the wait without error
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("rw_frz_ctl", C_FRZ);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("rw_rst_ctl", C_RST);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rw_stall", 32'(stall_cnt), 32'd0);
        chk("rw_err", 32'(mem_err), 32'd0);
        chk_ctl("rw_frz1_ctl", C_FRZ);
        // A fresh wait runs its full length, showing the wait counter restarted in RUN
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk_ctl("rw_frz_more_ctl", C_FRZ);
        end
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("rw_tmo_ctl", C_NORM);
        idle();
        chk("rw_stall4", 32'(stall_cnt), 32'd4);
        chk("rw_err_set", 32'(mem_err), 32'd1);

        // Saturation at 15 with CNT_W=4
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("sat_stall", 32'(stall_cnt), (i < 15) ? 32'(i) : 32'd15);
        end
        idle();
        chk("sat_final", 32'(stall_cnt), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, flushes on taken branches and freezes the pipeline while data memory is not ready.
- Bounds each memory wait with a timeout and keeps a saturating stall-cycle performance counter.
- Sits beside the pipeline registers and drives their write-enable and flush inputs.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive not-ready cycles tolerated for one data-memory access (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  pipeline clock, all state updates on posedge
rst  input  1  synchronous active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
idex_memread  input  1  MemRead of instruction in EX
idex_rt  input  5  load destination register of instruction in EX
branch_taken  input  1  branch resolved taken in EX this cycle
exmem_memread  input  1  MemRead of instruction in MEM
exmem_memwrite  input  1  MemWrite of instruction in MEM
mem_ready  input  1  data memory completes the current access this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register load enable
ifid_flush  output  1  clear IF/ID to NOP
idex_write  output  1  ID/EX register load enable
idex_flush  output  1  load bubble (all control 0) into ID/EX
exmem_write  output  1  EX/MEM register load enable
memwb_bubble  output  1  load bubble into MEM/WB (RegWrite=0)
mem_err  output  1  sticky: a memory access timed out
stall_cnt  output  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- Definitions:
  - mem_acc = exmem_memread | exmem_memwrite.
  - load_use = idex_memread & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt).
- States: RUN, MEM_WAIT. wait_cnt is 8 bits. State is registered; the control outputs are combinational from state, wait_cnt and the inputs.
- Timeout: tmo = (state == MEM_WAIT) & (wait_cnt == MEM_TIMEOUT-1) & !mem_ready.
- Freeze: freeze = mem_acc & !mem_ready & !tmo. Freeze has top priority.
  - pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_bubble=1.
  - ifid_flush=0, idex_flush=0.
  - branch_taken and load_use are ignored and stay held in their stages.
- Else, if branch_taken:
  - ifid_flush=1, idex_flush=1.
  - pc_write=1, ifid_write=1, idex_write=1, exmem_write=1, memwb_bubble=0.
  - load_use is ignored, because the ID instruction is squashed.
- Else, if load_use: one-cycle stall.
  - pc_write=0, ifid_write=0, idex_flush=1.
  - idex_write=1, exmem_write=1, memwb_bubble=0.
  - On the next cycle the load is in MEM, load_use is naturally false and the pipeline proceeds.
- Else (normal flow): all write enables=1, flushes=0, memwb_bubble=0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_acc & !mem_ready; wait_cnt <= 0. If mem_acc & mem_ready, stay in RUN (zero-wait access).
  - MEM_WAIT -> RUN when mem_ready. Freeze is released in that same cycle.
  - MEM_WAIT -> RUN when tmo. Also mem_err <= 1, and the access is treated as complete (freeze=0 that cycle).
  - Otherwise stay in MEM_WAIT; wait_cnt <= wait_cnt+1.
  - If mem_acc drops while in MEM_WAIT (not possible in correct operation), return to RUN.
- Wait length: a never-ready access freezes exactly MEM_TIMEOUT cycles counted from the first not-ready cycle in RUN, then releases.
- mem_err stays set until rst; later accesses run normally.
- stall_cnt:
  - Increments on every cycle with pc_write=0.
  - Holds at 2^CNT_W-1.
  - Branch flush cycles do not count.
- Reset (the cycle rst is high):
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
  - Outputs are forced: pc_write=1, ifid_write=1, idex_write=1, exmem_write=1, ifid_flush=1, idex_flush=1, memwb_bubble=1, so the pipeline fills with NOPs.
  - Reset mid-MEM_WAIT aborts the wait immediately; no mem_err is set.
- All comparisons are unsigned 5-bit. Register $0 never creates a hazard.

Test Plan:
- Load-use:
  - Stimulus: idex_memread=1, idex_rt=8, id_rs=8, no mem_acc.
  - Response: one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1.
  - Repeat with idex_rt=0: no stall.
- Branch flush:
  - Stimulus: branch_taken=1 together with load_use true.
  - Response: ifid_flush=1, idex_flush=1, pc_write=1; stall_cnt unchanged.
- Memory wait:
  - Stimulus: exmem_memread=1, mem_ready low for 3 cycles, then high.
  - Response: freeze for exactly 3 cycles (memwb_bubble=1, all writes 0); release on the mem_ready cycle; stall_cnt +3; mem_err=0.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, exmem_memwrite=1, mem_ready held 0.
  - Response: freeze for 4 cycles; 5th cycle pipeline advances; mem_err=1 from then on; state returns to RUN.
- Priority:
  - Stimulus: mem_acc & !mem_ready together with branch_taken and load_use.
  - Response: freeze only, no flushes. When mem_ready rises, the branch flush occurs in that cycle.
- Reset:
  - Stimulus: assert rst during the 2nd MEM_WAIT cycle.
  - Response: next cycle state=RUN, stall_cnt=0, mem_err=0; both flushes and memwb_bubble are high while rst=1.
  - Also check stall_cnt saturation with CNT_W=4: holds at 15.
